// File: rtl/mem_arbiter_if.sv
// Shared bus between the cache request side, the arbiter and the RAM port.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ramready;
    logic        err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore,
        input  ramload, ramready,
        output iwait, iload, dwait, dload,
        output ramREN, ramWEN, ramaddr, ramstore, err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore,
        output ramload, ramready,
        input  iwait, iload, dwait, dload,
        input  ramREN, ramWEN, ramaddr, ramstore, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (I/D) to single RAM port arbiter.
// Data has priority, with a streak limit on data grants and a stuck-access watchdog.
module mem_arbiter #(
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 255
) (
    input logic          CLK,
    input logic          nRST,
    mem_arbiter_if.slave bus
);
    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

    state_t        state_q;
    logic [SW-1:0] dstreak_q;
    logic [WW-1:0] wdog_q;
    logic          err_q;
    logic          ren_q;
    logic          wen_q;
    logic [31:0]   addr_q;
    logic [31:0]   store_q;

    logic dreq;
    logic force_i;
    logic tmo;

    assign dreq    = bus.dREN | bus.dWEN;
    assign force_i = dreq & bus.iREN & (dstreak_q == SW'(MAX_DSTREAK));
    assign tmo     = ~bus.ramready & (wdog_q == WW'(TIMEOUT - 1));

    // Latches are cleared on leaving a grant so the RAM port is idle in IDLE.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            dstreak_q <= '0;
            wdog_q    <= '0;
            err_q     <= 1'b0;
            ren_q     <= 1'b0;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            store_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (force_i || (!dreq && bus.iREN)) begin
                        state_q   <= IGRANT;
                        dstreak_q <= '0;
                        wdog_q    <= '0;
                        ren_q     <= 1'b1;
                        wen_q     <= 1'b0;
                        addr_q    <= bus.iaddr;
                        store_q   <= '0;
                    end else if (dreq) begin
                        state_q <= DGRANT;
                        wdog_q  <= '0;
                        ren_q   <= ~bus.dWEN;
                        wen_q   <= bus.dWEN;
                        addr_q  <= bus.daddr;
                        store_q <= bus.dstore;
                        if (!bus.iREN)
                            dstreak_q <= '0;
                        else if (dstreak_q != SW'(MAX_DSTREAK))
                            dstreak_q <= dstreak_q + 1'b1;
                    end
                end
                default: begin
                    if (bus.ramready || tmo) begin
                        state_q <= IDLE;
                        ren_q   <= 1'b0;
                        wen_q   <= 1'b0;
                        addr_q  <= '0;
                        store_q <= '0;
                        if (tmo)
                            err_q <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.ramREN   = ren_q;
    assign bus.ramWEN   = wen_q;
    assign bus.ramaddr  = addr_q;
    assign bus.ramstore = store_q;
    assign bus.err      = err_q;

    assign bus.iwait = ~((state_q == IGRANT) & bus.ramready);
    assign bus.dwait = ~((state_q == DGRANT) & bus.ramready);
    assign bus.iload = bus.ramload;
    assign bus.dload = bus.ramload;
endmodule
